instr_fetch_unit: RTL

//  Fetch stage that sits directly upstream of the combinational instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 11 +
 rtl/instr_fetch_unit_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready channel carrying {pc, instr} and pc+4.
interface instr_fetch_unit_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (output if_valid, if_instr, if_pc, if_pc_plus4, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, if_pc_plus4, output if_ready);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates what is ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC mux, fetch FSM and buffered {pc, instr} to decode.
//  state | meaning
//  FETCH | issuing one fetch per cycle while the buffer has room
//  HOLD  | halted; PC frozen, buffer drains to decode
//  TRAP  | misaligned redirect seen; idle until reset or aligned redirect
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [31:0]                imem_addr_o,
  input  logic [31:0]                imem_instr_i,
  input  logic                       redirect_valid_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       halt_i,
  output logic                       fetch_misaligned_o,
  instr_fetch_unit_if.master         dec
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic           misaligned_q, misaligned_d;

  logic           fire, pop, room, head_valid;
  logic           buf_full, buf_empty;
  logic [CW-1:0]  buf_count;
  fetch_entry_t   head, push_entry;

  assign head_valid = (buf_count != '0);
  assign pop        = head_valid & dec.if_ready;
  assign room       = ~buf_full | pop;
  assign push_entry = '{pc: pc_q, instr: imem_instr_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fire),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    fire         = 1'b0;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
      if (redirect_pc_i[1:0] == 2'b00) begin
        misaligned_d = 1'b0;
        state_d      = halt_i ? HOLD : FETCH;
      end else begin
        misaligned_d = 1'b1;
        state_d      = TRAP;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          fire = room;
          if (room)   pc_d    = pc_plus4(pc_q);
          if (halt_i) state_d = HOLD;
        end
        HOLD:    if (!halt_i) state_d = FETCH;
        TRAP:    state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_addr_o        = pc_q;
  assign fetch_misaligned_o = misaligned_q;

  assign dec.if_valid    = head_valid;
  assign dec.if_instr    = buf_empty ? NOP_INSTR : head.instr;
  assign dec.if_pc       = buf_empty ? 32'h0    : head.pc;
  assign dec.if_pc_plus4 = pc_plus4(dec.if_pc);

endmodule
